// File: rtl/fmv_ddr_arbiter.sv
// Round-robin arbiter merging NUM_WORKERS macroblock-worker DDR ports onto one FMV DDR port.
// Ownership is exclusive per acquire window; read beats are steered back to the owning worker.
//
//   state   | meaning
//   ST_ARB  | no owner; scanning w_acquire from rr_ptr, winner registered next cycle
//   ST_OWN  | worker `owner` drives the DDR port until it drops acquire with no beats outstanding
module fmv_ddr_arbiter #(
  parameter int NUM_WORKERS = 4,
  parameter int ADDR_W      = 29,
  parameter int DATA_W      = 64,
  parameter int BURST_W     = 8,
  localparam int OWN_W      = $clog2(NUM_WORKERS)
) (
  input  logic                          clk_mpeg,
  input  logic                          reset_n_clk_mpeg,
  input  logic [NUM_WORKERS-1:0]        w_acquire,
  input  logic [NUM_WORKERS-1:0]        w_read,
  input  logic [NUM_WORKERS-1:0]        w_write,
  input  logic [NUM_WORKERS*ADDR_W-1:0] w_addr,
  input  logic [NUM_WORKERS*BURST_W-1:0] w_burstcnt,
  input  logic [NUM_WORKERS*DATA_W-1:0] w_wdata,
  input  logic [NUM_WORKERS*8-1:0]      w_byteenable,
  output logic [NUM_WORKERS-1:0]        w_busy,
  output logic [DATA_W-1:0]             w_rdata,
  output logic [NUM_WORKERS-1:0]        w_rdata_ready,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [BURST_W-1:0]            mem_burstcnt,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [7:0]                    mem_byteenable,
  input  logic                          mem_busy,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rdata_ready,
  output logic [OWN_W-1:0]              owner,
  output logic                          proto_err
);

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_OWN = 1'b1;

  logic [0:0]         state;
  logic [OWN_W-1:0]   rr_ptr;
  logic [BURST_W-1:0] beats;
  logic [BURST_W-1:0] beats_next;
  logic               beats_nz;
  logic               found;
  logic [OWN_W-1:0]   winner;
  logic [OWN_W-1:0]   rr_next;
  logic               rd_accept;
  logic               beat_dec;
  logic               release_own;

  assign beats_nz = (beats != '0);

  // Command mux: only the owner reaches the DDR port; everyone else is stalled.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_burstcnt   = '0;
    mem_wdata      = '0;
    mem_byteenable = '0;
    w_busy         = '1;
    if (state == ST_OWN) begin
      mem_read       = w_read[owner];
      mem_write      = w_write[owner];
      mem_addr       = w_addr[int'(owner)*ADDR_W +: ADDR_W];
      mem_burstcnt   = w_burstcnt[int'(owner)*BURST_W +: BURST_W];
      mem_wdata      = w_wdata[int'(owner)*DATA_W +: DATA_W];
      mem_byteenable = w_byteenable[int'(owner)*8 +: 8];
      w_busy[owner]  = mem_busy;
    end
  end

  // A beat arriving with nothing outstanding belongs to nobody and is dropped.
  always_comb begin
    w_rdata              = mem_rdata;
    w_rdata_ready        = '0;
    w_rdata_ready[owner] = mem_rdata_ready && beats_nz;
  end

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_WORKERS;
      if (!found && w_acquire[idx]) begin
        found  = 1'b1;
        winner = OWN_W'(idx);
      end
    end
  end

  assign rr_next     = (int'(owner) == NUM_WORKERS - 1) ? '0 : owner + OWN_W'(1);
  assign rd_accept   = (state == ST_OWN) && mem_read && !mem_busy;
  assign beat_dec    = mem_rdata_ready && beats_nz;
  assign release_own = (state == ST_OWN) && !w_acquire[owner] && !beats_nz;

  always_comb begin
    beats_next = beats;
    if (rd_accept) beats_next = beats_next + mem_burstcnt;
    if (beat_dec)  beats_next = beats_next - BURST_W'(1);
  end

  always_ff @(posedge clk_mpeg or negedge reset_n_clk_mpeg) begin
    if (!reset_n_clk_mpeg) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      beats     <= '0;
      proto_err <= 1'b0;
    end else begin
      beats <= beats_next;
      if (mem_rdata_ready && !beats_nz) proto_err <= 1'b1;
      case (state)
        ST_ARB: begin
          if (found) begin
            owner <= winner;
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (release_own) begin
            rr_ptr <= rr_next;
            state  <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fmv_ddr_arbiter.sv
// Bench for fmv_ddr_arbiter: directed scenarios plus randomized workers/DDR,
// all checked every cycle against a behavioural ownership/beat-count model.
module tb_fmv_ddr_arbiter;
  localparam int N  = 4;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk_mpeg = 1'b0;
  logic reset_n_clk_mpeg;
  logic [N-1:0]    w_acquire, w_read, w_write;
  logic [N*AW-1:0] w_addr;
  logic [N*BW-1:0] w_burstcnt;
  logic [N*DW-1:0] w_wdata;
  logic [N*8-1:0]  w_byteenable;
  logic [N-1:0]    w_busy, w_rdata_ready;
  logic [DW-1:0]   w_rdata;
  logic            mem_read, mem_write;
  logic [AW-1:0]   mem_addr;
  logic [BW-1:0]   mem_burstcnt;
  logic [DW-1:0]   mem_wdata;
  logic [7:0]      mem_byteenable;
  logic            mem_busy;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rdata_ready;
  logic [1:0]      owner;
  logic            proto_err;

  fmv_ddr_arbiter #(.NUM_WORKERS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk_mpeg(clk_mpeg), .reset_n_clk_mpeg(reset_n_clk_mpeg),
    .w_acquire(w_acquire), .w_read(w_read), .w_write(w_write), .w_addr(w_addr),
    .w_burstcnt(w_burstcnt), .w_wdata(w_wdata), .w_byteenable(w_byteenable),
    .w_busy(w_busy), .w_rdata(w_rdata), .w_rdata_ready(w_rdata_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_burstcnt(mem_burstcnt), .mem_wdata(mem_wdata), .mem_byteenable(mem_byteenable),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready),
    .owner(owner), .proto_err(proto_err)
  );

  always #5 clk_mpeg = ~clk_mpeg;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the port, where the next scan starts, beats still owed.
  bit m_own;
  int m_owner, m_rr, m_beats;
  bit m_perr;
  logic [N-1:0] last_busy;
  int last_acc;
  int ddr_pending;
  int cmds[N];
  int gap[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_perr = 0;
  endtask

  task automatic set_cmd(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc);
    w_read[k]  = rd;
    w_write[k] = wr;
    w_addr[k*AW +: AW]   = a;
    w_burstcnt[k*BW +: BW] = bc;
    w_wdata[k*DW +: DW]  = {$urandom, $urandom};
    w_byteenable[k*8 +: 8] = 8'($urandom);
  endtask

  task automatic clear_inputs();
    w_acquire = '0; w_read = '0; w_write = '0; w_addr = '0; w_burstcnt = '0;
    w_wdata = '0; w_byteenable = '0; mem_busy = 0; mem_rdata = '0; mem_rdata_ready = 0;
  endtask

  // Mid-cycle: compare every output against the model, record what the workers/DDR saw.
  task automatic settle();
    int o;
    logic [N-1:0] e_busy, e_rdy;
    logic e_mr, e_mw;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bc;
    logic [DW-1:0] e_wd;
    logic [7:0] e_be;
    #4;
    o = m_owner;
    e_busy = '1; e_mr = 0; e_mw = 0; e_addr = '0; e_bc = '0; e_wd = '0; e_be = '0;
    if (m_own) begin
      e_mr = w_read[o]; e_mw = w_write[o];
      e_addr = w_addr[o*AW +: AW]; e_bc = w_burstcnt[o*BW +: BW];
      e_wd = w_wdata[o*DW +: DW]; e_be = w_byteenable[o*8 +: 8];
      e_busy[o] = mem_busy;
    end
    e_rdy = '0;
    if (mem_rdata_ready && m_beats != 0) e_rdy[o] = 1'b1;
    chk("mem_read", 64'(mem_read), 64'(e_mr));
    chk("mem_write", 64'(mem_write), 64'(e_mw));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_burstcnt", 64'(mem_burstcnt), 64'(e_bc));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_byteenable", 64'(mem_byteenable), 64'(e_be));
    chk("w_busy", 64'(w_busy), 64'(e_busy));
    chk("w_rdata_ready", 64'(w_rdata_ready), 64'(e_rdy));
    chk("w_rdata", w_rdata, mem_rdata);
    chk("owner", 64'(owner), 64'(o));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    last_busy = e_busy;
    last_acc  = (m_own && e_mr && !mem_busy) ? int'(e_bc) : 0;
  endtask

  task automatic tick();
    int o, nb;
    bit found;
    if (reset_n_clk_mpeg) begin
      o  = m_owner;
      nb = m_beats + last_acc - ((mem_rdata_ready && m_beats != 0) ? 1 : 0);
      if (mem_rdata_ready && m_beats == 0) m_perr = 1;
      if (!m_own) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          if (!found && w_acquire[(m_rr + i) % N]) begin
            found = 1; m_owner = (m_rr + i) % N; m_own = 1;
          end
        end
      end else if (!w_acquire[o] && m_beats == 0) begin
        m_own = 0; m_rr = (o + 1) % N;
      end
      m_beats = nb;
    end
    @(posedge clk_mpeg); #1;
  endtask

  task automatic step();
    settle(); tick();
  endtask

  task automatic do_reset();
    reset_n_clk_mpeg = 0;
    model_reset();
    clear_inputs();
    repeat (2) @(posedge clk_mpeg);
    #1 reset_n_clk_mpeg = 1;
  endtask

  // Randomized workers honouring the ddr_if protocol, and a DDR that owes exactly the accepted beats.
  task automatic gen();
    bit cmd;
    ddr_pending += last_acc;
    for (int k = 0; k < N; k++) begin
      cmd = w_read[k] | w_write[k];
      if (cmd && !last_busy[k]) begin
        w_read[k] = 0; w_write[k] = 0; cmd = 0;
      end
      if (!cmd) begin
        if (w_acquire[k]) begin
          if (cmds[k] > 0) begin
            if ($urandom % 2 == 0) begin
              if ($urandom % 2 == 0) set_cmd(k, 1, 0, AW'($urandom), BW'($urandom_range(1, 4)));
              else                   set_cmd(k, 0, 1, AW'($urandom), BW'($urandom_range(1, 4)));
              cmds[k]--;
            end
          end else if ($urandom % 3 == 0) begin
            w_acquire[k] = 0; gap[k] = $urandom_range(0, 6);
          end
        end else if (gap[k] > 0) begin
          gap[k]--;
        end else if ($urandom % 4 == 0) begin
          w_acquire[k] = 1; cmds[k] = $urandom_range(1, 3);
        end
      end
    end
    mem_busy = ($urandom % 4 == 0);
    mem_rdata = {$urandom, $urandom};
    if (ddr_pending > 0 && $urandom % 2 == 0) begin
      mem_rdata_ready = 1; ddr_pending--;
    end else begin
      mem_rdata_ready = 0;
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset_n_clk_mpeg = 0;
    #2;
    chk("rst_busy", 64'(w_busy), 64'hF);
    chk("rst_mread", 64'(mem_read), 64'h0);
    chk("rst_rdy", 64'(w_rdata_ready), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_perr", 64'(proto_err), 64'h0);
    repeat (2) @(posedge clk_mpeg);
    #1 reset_n_clk_mpeg = 1;

    // Single read, burst 3
    w_acquire[0] = 1;
    set_cmd(0, 1, 0, 29'h3000010, 8'd3);
    settle(); chk("t1_arb_busy", 64'(w_busy), 64'hF); chk("t1_arb_mread", 64'(mem_read), 0); tick();
    settle(); chk("t1_mread", 64'(mem_read), 1); chk("t1_addr", 64'(mem_addr), 64'h3000010);
    chk("t1_burst", 64'(mem_burstcnt), 3); chk("t1_busy", 64'(w_busy), 64'hE); tick();
    w_read[0] = 0;
    for (int b = 0; b < 3; b++) begin
      mem_rdata_ready = 1; mem_rdata = {$urandom, $urandom};
      settle(); chk("t1_beat", 64'(w_rdata_ready), 64'h1); tick();
    end
    mem_rdata_ready = 0; w_acquire[0] = 0;
    settle(); chk("t1_hold_owner", 64'(w_busy), 64'hE); tick();
    settle(); chk("t1_release", 64'(w_busy), 64'hF); tick();

    // Contention from rr_ptr=0
    do_reset();
    w_acquire = 4'hF;
    settle(); chk("t2_first_arb", 64'(w_busy), 64'hF); tick();
    for (int g = 0; g < N; g++) begin
      w_acquire[g] = 0;
      settle(); chk("t2_owner", 64'(owner), 64'(g)); chk("t2_busy", 64'(w_busy), 64'(4'hF & ~(4'b1 << g))); tick();
      settle(); chk("t2_gap", 64'(w_busy), 64'hF); tick();
    end

    // Write stalled 5 cycles
    w_acquire[2] = 1;
    set_cmd(2, 0, 1, 29'h0123456, 8'd1);
    step();
    mem_busy = 1;
    for (int c = 0; c < 5; c++) begin
      settle(); chk("t3_mwrite_held", 64'(mem_write), 1); chk("t3_stall", 64'(w_busy), 64'hF); tick();
    end
    mem_busy = 0;
    settle(); chk("t3_accept", 64'(w_busy), 64'hB); chk("t3_mwrite", 64'(mem_write), 1); tick();
    w_write[2] = 0; w_acquire[2] = 0;
    step();
    settle(); chk("t3_no_beats", 64'(w_busy), 64'hF); tick();

    // Early acquire drop; rr_ptr is 3 here
    w_acquire[1] = 1;
    set_cmd(1, 1, 0, AW'($urandom), 8'd3);
    step();
    settle(); chk("t4_owner", 64'(owner), 1); tick();
    w_read[1] = 0; w_acquire[3] = 1; mem_rdata_ready = 1;
    settle(); chk("t4_beat1", 64'(w_rdata_ready), 64'h2); tick();
    w_acquire[1] = 0;
    settle(); chk("t4_beat2_owner", 64'(owner), 1); chk("t4_beat2", 64'(w_rdata_ready), 64'h2); tick();
    settle(); chk("t4_beat3_owner", 64'(owner), 1); chk("t4_beat3_busy", 64'(w_busy), 64'hD); tick();
    mem_rdata_ready = 0;
    settle(); chk("t4_last_own", 64'(w_busy), 64'hD); tick();
    settle(); chk("t4_arb", 64'(w_busy), 64'hF); tick();
    settle(); chk("t4_next_owner", 64'(owner), 3); chk("t4_next_busy", 64'(w_busy), 64'h7); tick();
    w_acquire = '0;
    step(); step();

    // Stray beat in ARB
    mem_rdata_ready = 1;
    settle(); chk("t5_rdy", 64'(w_rdata_ready), 0); chk("t5_perr_before", 64'(proto_err), 0); tick();
    mem_rdata_ready = 0;
    for (int c = 0; c < 3; c++) begin
      settle(); chk("t5_perr_sticky", 64'(proto_err), 1); tick();
    end

    // Reset after beat 1 of 3
    do_reset();
    w_acquire[0] = 1;
    set_cmd(0, 1, 0, AW'($urandom), 8'd3);
    step(); step();
    w_read[0] = 0; mem_rdata_ready = 1;
    step();
    mem_rdata_ready = 0;
    #2 reset_n_clk_mpeg = 0;
    model_reset();
    #1;
    chk("t6_busy", 64'(w_busy), 64'hF);
    chk("t6_perr", 64'(proto_err), 0);
    chk("t6_mread", 64'(mem_read), 0);
    chk("t6_rdy", 64'(w_rdata_ready), 0);
    w_acquire = '0;
    @(posedge clk_mpeg); #1;
    reset_n_clk_mpeg = 1;
    mem_rdata_ready = 1;
    settle(); chk("t6_rdy_after", 64'(w_rdata_ready), 0); tick();
    settle(); chk("t6_perr_set", 64'(proto_err), 1); tick();
    mem_rdata_ready = 0;
    step();

    // Randomized traffic
    do_reset();
    last_busy = '1; last_acc = 0; ddr_pending = 0;
    for (int k = 0; k < N; k++) begin cmds[k] = 0; gap[k] = 0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      gen();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
